// File: rtl/shift_sio_reg.sv
// Serial-in/parallel-out latch register for the host GPIO link, with serial readback of pin.
// Async host pins are synchronised to clk; edge events are registered before they act.
module shift_sio_reg #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned STRICT      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs,
    input  logic             le,
    input  logic             din,
    input  logic [WIDTH-1:0] pin,
    output logic             dout_ser,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             frame_err
);

    localparam int unsigned CntW = $clog2(WIDTH + 2);
    localparam logic [CntW-1:0] CntWidth = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntMax   = CntW'(WIDTH + 1);
    localparam int unsigned SetW = $clog2(SYNC_STAGES + 2);
    localparam logic [SetW-1:0] SetMax = SetW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, le_sync, din_sync;
    logic sclk_s, cs_s, le_s, din_s;
    logic sclk_prev, cs_prev;
    logic sclk_rise, cs_rise, cs_fall;
    logic ev_shift, ev_latch, ev_cs_rise, ev_cs_fall, ev_din;
    logic [SetW-1:0] settle;
    logic settled;
    logic frame_active;
    logic [CntW-1:0] count;
    logic [WIDTH-1:0] shreg, rbreg;
    logic [WIDTH-1:0] shreg_next, rbreg_next;
    logic latch_ok;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign le_s   = le_sync[SYNC_STAGES-1];
    assign din_s  = din_sync[SYNC_STAGES-1];

    // cs edges are ignored until the synchronisers hold real pin values, so a cs held
    // high through reset release is not mistaken for a fresh frame start.
    assign settled   = (settle == SetMax);
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev & settled;
    assign cs_fall   = ~cs_s & cs_prev;

    always_comb begin
        shreg_next = shreg;
        rbreg_next = rbreg;
        dout_ser   = 1'b0;
        if (MSB_FIRST != 0) begin
            shreg_next = {shreg[WIDTH-2:0], ev_din};
            rbreg_next = {rbreg[WIDTH-2:0], 1'b0};
            dout_ser   = rbreg[WIDTH-1];
        end else begin
            shreg_next = {ev_din, shreg[WIDTH-1:1]};
            rbreg_next = {1'b0, rbreg[WIDTH-1:1]};
            dout_ser   = rbreg[0];
        end
        latch_ok = (STRICT != 0) ? (count == CntWidth) : (count >= CntWidth);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync    <= '0;
            cs_sync      <= '0;
            le_sync      <= '0;
            din_sync     <= '0;
            sclk_prev    <= 1'b0;
            cs_prev      <= 1'b0;
            ev_shift     <= 1'b0;
            ev_latch     <= 1'b0;
            ev_cs_rise   <= 1'b0;
            ev_cs_fall   <= 1'b0;
            ev_din       <= 1'b0;
            settle       <= '0;
            frame_active <= 1'b0;
            count        <= '0;
            shreg        <= '0;
            rbreg        <= '0;
            pout         <= '0;
            pout_valid   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            le_sync   <= {le_sync[SYNC_STAGES-2:0], le};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            if (!settled) begin
                settle <= settle + SetW'(1);
            end

            ev_shift   <= sclk_rise & cs_s & frame_active & ~le_s;
            ev_latch   <= sclk_rise & cs_s & frame_active & le_s;
            ev_cs_rise <= cs_rise;
            ev_cs_fall <= cs_fall;
            ev_din     <= din_s;

            if (cs_rise) begin
                frame_active <= 1'b1;
            end else if (cs_fall) begin
                frame_active <= 1'b0;
            end

            pout_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (ev_cs_rise) begin
                count <= '0;
                rbreg <= pin;
            end else if (ev_cs_fall) begin
                count <= '0;
            end else if (ev_shift) begin
                shreg <= shreg_next;
                rbreg <= rbreg_next;
                count <= (count == CntMax) ? CntMax : count + CntW'(1);
            end else if (ev_latch) begin
                count <= '0;
                if (latch_ok) begin
                    pout       <= shreg;
                    pout_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/shift_sio_reg.md
Name: shift_sio_reg

Overview:
- Parametrised successor to the 8-bit serial-in/parallel-out latch register on the host (Raspberry Pi) GPIO serial link.
- Host drives sclk/cs/le/din asynchronously; the block synchronises them to clk, counts bits per frame and shifts data in.
- Commits the shifted word to pout only on a correctly sized frame, and flags a bad frame otherwise.
- Shifts a snapshot of pin back out on dout_ser during the same frame for host readback.

Parameters:
- WIDTH, 8, data word width in bits (2..32).
- SYNC_STAGES, 2, synchroniser flops on each async input (2..3).
- MSB_FIRST, 1, 1: first bit received ends in pout[WIDTH-1] and pin[WIDTH-1] is sent first; 0: LSB end for both.
- STRICT, 1, 1: latch requires exactly WIDTH bits; 0: latch requires at least WIDTH bits, and the last WIDTH bits are kept.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sclk  in  1  async host serial clock; acts on its rising edge
- cs  in  1  async frame select, active high
- le  in  1  async latch enable; an sclk rising edge with le high commits instead of shifting
- din  in  1  async serial data
- pin  in  WIDTH  parallel word for readback, snapshotted at frame start
- dout_ser  out  1  serial readback bit
- pout  out  WIDTH  latched parallel word
- pout_valid  out  1  one-clk pulse when pout updates
- frame_err  out  1  one-clk pulse on a rejected latch

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: pout=0, pout_valid=0, frame_err=0, dout_ser=0; shift register, readback register, bit counter and all synchroniser/edge flops = 0.
- Reset mid-frame: frame discarded; after release the block waits for a fresh cs rising edge.
- Synchronisers: sclk, cs, le and din each pass through SYNC_STAGES flops. The rising-edge detector is one further flop on synced sclk, compared with the synced value. The same compare on synced cs gives the cs rising and falling edges.
- Event (clk cycle where the sclk rising edge is detected), with synced cs=1:
  - le=0, shift: shift register takes din at the MSB_FIRST-defined end; readback register advances one bit; bit counter increments, saturating at WIDTH+1.
  - le=1, latch check: if count==WIDTH (STRICT=1) or count>=WIDTH (STRICT=0), pout <= shift register and pout_valid pulses. Otherwise pout holds and frame_err pulses. In both cases the counter clears and no shift occurs.
- An sclk edge while synced cs=0 is ignored.
- cs rising edge: counter clears; readback register <= pin; dout_ser shows the first bit. Each shift presents the next bit; after WIDTH shifts dout_ser=0.
- cs falling edge: counter clears; pout is not touched. The shift register contents are retained but never committed without a new frame.
- Latency: pout and pout_valid update on the (SYNC_STAGES+2)th clk edge counting the first edge that samples sclk high. dout_ser changes on the same edge as the corresponding shift.
- Pulse widths: pout_valid and frame_err are exactly one clk wide.
- Repeated le edges: a second le edge without new shifts has count 0, so it is rejected (frame_err).
- Host timing: sclk high and low must each last at least SYNC_STAGES+1 clk periods. din, le and cs must be stable SYNC_STAGES+1 clk periods before the sclk rise.

Test Plan:
- Reset, WIDTH=8, MSB_FIRST=1: cs high, shift 1,0,1,0,0,1,0,1, then le+sclk -> pout=8'hA5 with one pout_valid pulse at the specified latency; frame_err stays 0.
- Short frame, STRICT=1: 7 shifts then latch -> frame_err pulses once, pout unchanged (8'hA5). A following clean 8-bit frame of 8'h3C -> pout=8'h3C.
- Long frame: shift 10 bits ending 0x5A. STRICT=1 -> frame_err, pout unchanged. STRICT=0 -> pout=8'h5A.
- Readback: pin=8'hC3 at cs rise, pin changed to 8'h00 mid-frame -> dout_ser sequence over 8 shifts is 1,1,0,0,0,0,1,1; MSB_FIRST=0 gives 1,1,0,0,0,0,1,1 reversed bit order (LSB first).
- Gating: sclk toggled with cs=0 -> no shift, no pulses. cs dropped after 4 bits, then a new 8-bit frame of 8'h81 -> pout=8'h81.
- rst_n asserted after 5 bits -> all outputs 0. A full frame of 8'hFF after release latches 8'hFF.
